// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector
//
// Serial sequence detector for a PAT_W-bit pattern that can be reloaded at run
// time. Qualified input bits shift into a history register, and the history is
// compared against the pattern register. A match produces a registered
// one-cycle pulse on Out. Both overlapping and non-overlapping detection are
// supported.
//
// Parameters:
//   PAT_W     pattern length in bits (2..32)
//   PAT_INIT  pattern register value after reset
//   CNT_W     match counter width (1..16)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   InA        serial data bit
//   in_valid   InA is sampled only when high
//   load       load `pattern`; aborts any partial sequence
//   pattern    new pattern, first-received bit is the MSB
//   overlap    1 = overlapping detection, 0 = non-overlapping
//   clr_cnt    clear the match counter
//   Out        registered match pulse
//   match_cnt  saturating match count
//   armed      history holds at least PAT_W valid bits
//
// Build option: define SERIAL_PATTERN_DETECTOR_CNT_EN to build the saturating
// match counter. Without it, match_cnt is tied to 0 and clr_cnt is ignored.

module serial_pattern_detector #(
  parameter int              PAT_W    = 8,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(8'b1001_1011),
  parameter int              CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InA,
  input  logic             in_valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             Out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] pat_r;
  logic [PAT_W-1:0] hist;
  logic [FW-1:0]    fill;

  logic [PAT_W-1:0] hist_shift;
  logic [FW-1:0]    fill_inc;
  logic             match;
  logic [PAT_W-1:0] hist_d;
  logic [FW-1:0]    fill_d;

  // The match is evaluated on the post-shift view, so Out rises on the edge
  // that samples the final pattern bit.
  always_comb begin
    hist_shift = {hist[PAT_W-2:0], InA};
    fill_inc   = (fill == FULL) ? FULL : fill + FW'(1);
    match      = in_valid & ~load & (fill_inc == FULL) & (hist_shift == pat_r);

    hist_d = hist;
    fill_d = fill;
    if (load) begin
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      if (match && !overlap) begin
        // In non-overlapping mode, the next match needs PAT_W fresh bits.
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_shift;
        fill_d = fill_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r <= PAT_INIT;
      hist  <= '0;
      fill  <= '0;
      Out   <= 1'b0;
      armed <= 1'b0;
    end else begin
      if (load) pat_r <= pattern;
      hist  <= hist_d;
      fill  <= fill_d;
      Out   <= match;
      armed <= (fill_d == FULL);
    end
  end

  // The oldest history bit is shifted out before the compare, so it only
  // exists to keep the history register PAT_W bits wide.
  logic unused_hist_msb;
  assign unused_hist_msb = hist[PAT_W-1];

`ifdef SERIAL_PATTERN_DETECTOR_CNT_EN
  logic [CNT_W-1:0] cnt;

  // When clr_cnt coincides with a match, the counter clears and then counts
  // that match, so it ends at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= match ? CNT_W'(1) : '0;
    end else if (match && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match_cnt = cnt;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_serial_pattern_detector.sv
module tb_serial_pattern_detector;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam logic [PAT_W-1:0] INIT = 4'b1101;

  logic clk = 1'b0;
  logic rst, InA, in_valid, load, overlap, clr_cnt;
  logic [PAT_W-1:0] pattern;
  logic Out, armed;
  logic [CNT_W-1:0] match_cnt;

  int n_vec = 0;
  int n_err = 0;

  serial_pattern_detector #(
    .PAT_W(PAT_W), .PAT_INIT(INIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .InA(InA), .in_valid(in_valid), .load(load),
    .pattern(pattern), .overlap(overlap), .clr_cnt(clr_cnt),
    .Out(Out), .match_cnt(match_cnt), .armed(armed)
  );

  always #5 clk = ~clk;

  // Reference model: the bits received since the last abort, kept in a queue.
  bit          mq[$];
  logic [3:0]  m_pat;
  int          m_cnt;
  logic        m_out, m_armed;

  function automatic int cnt_exp(int c);
`ifdef SERIAL_PATTERN_DETECTOR_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  function automatic logic [3:0] q_value();
    logic [3:0] v = '0;
    foreach (mq[i]) v = {v[2:0], mq[i]};
    return v;
  endfunction

  task automatic model(input logic r, ld, v, a, ov, cl, input logic [3:0] p);
    bit hit = 0;
    if (r) begin
      m_pat = INIT; mq.delete(); m_cnt = 0;
    end else begin
      if (ld) begin
        m_pat = p; mq.delete();
      end else if (v) begin
        mq.push_back(a);
        if (mq.size() > PAT_W) void'(mq.pop_front());
        if (mq.size() == PAT_W && q_value() == m_pat) hit = 1;
        if (hit && !ov) mq.delete();
      end
      if (cl) m_cnt = hit ? 1 : 0;
      else if (hit && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    m_out   = hit;
    m_armed = (mq.size() == PAT_W);
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, ld, v, a, ov, cl, input logic [3:0] p);
    @(negedge clk);
    rst = r; load = ld; in_valid = v; InA = a; overlap = ov; clr_cnt = cl; pattern = p;
    @(posedge clk);
    model(r, ld, v, a, ov, cl, p);
    #1;
    check("model_out", int'(Out), int'(m_out));
    check("model_armed", int'(armed), int'(m_armed));
    check("model_cnt", int'(match_cnt), cnt_exp(m_cnt));
  endtask

  typedef struct {
    logic r, ld, v, a, ov, cl;
    logic [3:0] p;
    logic e_out, e_armed;
    int   e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, ld, v, a, ov, cl, logic [3:0] p,
                              logic eo, ea, int ec);
    vec_t t;
    t.r = r; t.ld = ld; t.v = v; t.a = a; t.ov = ov; t.cl = cl; t.p = p;
    t.e_out = eo; t.e_armed = ea; t.e_cnt = ec;
    return t;
  endfunction

  int pulses;

  task automatic bit_in(input logic a, input logic ov);
    step(0, 0, 1, a, ov, 0, 4'b0);
    if (Out) pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, 1, 0, 4'b0);
      if (Out) pulses++;
    end
  endtask

  initial begin
    rst = 1; load = 0; in_valid = 0; InA = 0; overlap = 1; clr_cnt = 0; pattern = '0;
    m_pat = INIT; m_cnt = 0; m_out = 0; m_armed = 0;

    // r ld v a ov cl pattern | out armed cnt
    tbl.push_back(mk(1,0,1,1,1,0,4'b0000, 0,0,0));
    tbl.push_back(mk(1,0,1,1,1,0,4'b0000, 0,0,0));
    // reset pattern 1101 is detected
    tbl.push_back(mk(0,0,1,1,1,0,4'b0000, 0,0,0));
    tbl.push_back(mk(0,0,1,1,1,0,4'b0000, 0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0,4'b0000, 0,0,0));
    tbl.push_back(mk(0,0,1,1,1,0,4'b0000, 1,1,1));
    // overlapping 1011 over 1,0,1,1,0,1,1
    tbl.push_back(mk(0,1,0,0,1,1,4'b1011, 0,0,0));
    tbl.push_back(mk(0,0,1,1,1,0,4'b0000, 0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0,4'b0000, 0,0,0));
    tbl.push_back(mk(0,0,1,1,1,0,4'b0000, 0,0,0));
    tbl.push_back(mk(0,0,1,1,1,0,4'b0000, 1,1,1));
    tbl.push_back(mk(0,0,1,0,1,0,4'b0000, 0,1,1));
    tbl.push_back(mk(0,0,1,1,1,0,4'b0000, 0,1,1));
    tbl.push_back(mk(0,0,1,1,1,0,4'b0000, 1,1,2));
    // non-overlapping, same stream
    tbl.push_back(mk(0,1,0,0,0,1,4'b1011, 0,0,0));
    tbl.push_back(mk(0,0,1,1,0,0,4'b0000, 0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,4'b0000, 0,0,0));
    tbl.push_back(mk(0,0,1,1,0,0,4'b0000, 0,0,0));
    tbl.push_back(mk(0,0,1,1,0,0,4'b0000, 1,0,1));
    tbl.push_back(mk(0,0,1,0,0,0,4'b0000, 0,0,1));
    tbl.push_back(mk(0,0,1,1,0,0,4'b0000, 0,0,1));
    tbl.push_back(mk(0,0,1,1,0,0,4'b0000, 0,0,1));
    // load discards a coincident valid bit; counter is kept
    tbl.push_back(mk(0,1,1,1,1,0,4'b1011, 0,0,1));
    tbl.push_back(mk(0,0,1,0,1,0,4'b0000, 0,0,1));
    tbl.push_back(mk(0,0,1,1,1,0,4'b0000, 0,0,1));
    tbl.push_back(mk(0,0,1,1,1,0,4'b0000, 0,0,1));
    tbl.push_back(mk(0,0,1,1,1,0,4'b0000, 0,1,1));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].ld, tbl[i].v, tbl[i].a, tbl[i].ov, tbl[i].cl, tbl[i].p);
      check($sformatf("tbl%0d_out", i), int'(Out), int'(tbl[i].e_out));
      check($sformatf("tbl%0d_armed", i), int'(armed), int'(tbl[i].e_armed));
      check($sformatf("tbl%0d_cnt", i), int'(match_cnt), cnt_exp(tbl[i].e_cnt));
    end

    // Valid gaps stretch but do not break detection.
    step(0, 1, 0, 0, 1, 1, 4'b1011);
    pulses = 0;
    bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);
    idle(3);
    bit_in(1, 1);
    check("gap_pulses", pulses, 1);
    check("gap_out_last", int'(Out), 1);

    // Mid-stream load aborts the partial sequence.
    step(0, 1, 0, 0, 1, 0, 4'b1011);
    pulses = 0;
    bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);
    step(0, 1, 0, 0, 1, 0, 4'b0000);
    if (Out) pulses++;
    idle(2);
    check("abort_pulses", pulses, 0);
    check("abort_armed", int'(armed), 0);
    pulses = 0;
    bit_in(0, 1); bit_in(0, 1); bit_in(0, 1);
    check("zeros_early", pulses, 0);
    bit_in(0, 1);
    check("zeros_pulse", pulses, 1);

    // Saturation with an all-ones pattern: one pulse per valid cycle once armed.
    step(0, 1, 0, 0, 1, 1, 4'b1111);
    pulses = 0;
    for (int i = 0; i < 8; i++) bit_in(1, 1);
    check("ones_pulses", pulses, 5);
    check("sat_cnt", int'(match_cnt), cnt_exp(3));
    step(0, 0, 1, 1, 1, 1, 4'b0);
    check("clr_with_match", int'(match_cnt), cnt_exp(1));
    step(0, 0, 0, 0, 1, 1, 4'b0);
    check("clr_alone", int'(match_cnt), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic r, ld, cl, v, a, ov;
      logic [3:0] p;
      r  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 39) == 0);
      cl = ($urandom_range(0, 29) == 0);
      v  = ($urandom_range(0, 3) != 0);
      a  = 1'($urandom);
      ov = ($urandom_range(0, 3) != 0);
      p  = 4'($urandom);
      step(r, ld, v, a, ov, cl, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
